instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue_pkg.sv | 29 ++
 rtl/instr_fetch_queue_fetch_queue.sv | 71 +++++++
 rtl/instr_fetch_queue.sv | 108 ++++++++++
 tb/tb_instr_fetch_queue.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared memory-access definitions plus the fetch FSM encoding used by instr_fetch_queue.
package instr_fetch_queue_pkg;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [1:0] SIZE_DWORD = 2'b11;

    localparam int INSTR_W    = 32;
    localparam int ADDR_W     = 32;
    localparam int LINE_BYTES = 8;

    // Bit 0 = a read is on the bus this cycle, bit 1 = its response is sampled this cycle.
    typedef enum logic [1:0] {
        IDLE          = 2'b00,
        ISSUE         = 2'b01,
        CAPTURE       = 2'b10,
        ISSUE_CAPTURE = 2'b11
    } fetch_state_t;

    function automatic fetch_state_t next_state(input logic issue, input logic capture);
        return fetch_state_t'({capture, issue});
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/instr_fetch_queue_fetch_queue.sv
// Instruction FIFO: two-entry write port, one-entry read port, flush and occupancy count.
module fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               wr_en,
    input  logic               wr_two,
    input  logic [INSTR_W-1:0] wr_data0,
    input  logic [ADDR_W-1:0]  wr_pc0,
    input  logic [INSTR_W-1:0] wr_data1,
    input  logic [ADDR_W-1:0]  wr_pc1,
    input  logic               rd_en,
    output logic [INSTR_W-1:0] rd_data,
    output logic [ADDR_W-1:0]  rd_pc,
    output logic [CNT_W-1:0]   count
);

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   wr_ptr1;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   wr_n;

    assign wr_ptr1 = wr_ptr + 1'b1;
    assign rd_data = instr_mem[rd_ptr];
    assign rd_pc   = pc_mem[rd_ptr];

    always_comb begin
        wr_n = '0;
        if (wr_en) begin
            wr_n = wr_two ? CNT_W'(2) : CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en && !flush) begin
            instr_mem[wr_ptr] <= wr_data0;
            pc_mem[wr_ptr]    <= wr_pc0;
            if (wr_two) begin
                instr_mem[wr_ptr1] <= wr_data1;
                pc_mem[wr_ptr1]    <= wr_pc1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + wr_n[PTR_W-1:0];
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + wr_n - CNT_W'(rd_en);
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: issues 8-byte ROM reads and splits each line into two queued instructions.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h00000000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] address,
    output logic        mem_read,
    output logic [1:0]  size,
    input  logic [63:0] data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t       state;
    logic [31:0]        fetch_addr;
    logic [31:0]        cap_addr;
    logic               issue_half;
    logic               cap_half;
    logic               issuing;
    logic               capturing;
    logic               can_issue;
    int                 committed;
    logic               enq;
    logic               deq;
    logic [CNT_W-1:0]   count;
    logic [INSTR_W-1:0] head_data;
    logic [ADDR_W-1:0]  head_pc;
    logic               unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];
    assign size      = SIZE_DWORD;
    assign issuing   = (state == ISSUE) || (state == ISSUE_CAPTURE);
    assign capturing = (state == CAPTURE) || (state == ISSUE_CAPTURE);

    // Space is reserved for both lines that may still land: the one being sampled and the one on the bus.
    always_comb begin
        committed = int'(count) + (issuing ? 2 : 0) + (capturing ? 2 : 0);
        can_issue = (QUEUE_DEPTH - committed) >= 2;
    end

    assign enq = capturing && !redirect;
    assign deq = instr_valid && instr_ready && !redirect;

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? head_data : '0;
    assign instr_pc    = instr_valid ? head_pc : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            mem_read   <= 1'b0;
            address    <= RESET_PC;
            fetch_addr <= RESET_PC;
            issue_half <= 1'b0;
            cap_half   <= 1'b0;
        end else begin
            if (redirect) begin
                mem_read   <= 1'b1;
                address    <= line_addr(redirect_pc);
                fetch_addr <= line_addr(redirect_pc) + 32'd8;
                issue_half <= redirect_pc[2];
            end else if (can_issue) begin
                mem_read   <= 1'b1;
                address    <= line_addr(fetch_addr);
                fetch_addr <= line_addr(fetch_addr) + 32'd8;
                issue_half <= 1'b0;
            end else begin
                mem_read <= 1'b0;
            end
            cap_half <= issue_half;
            // A redirect kills the line currently on the bus; it must never reach the queue.
            state <= next_state(redirect || can_issue, issuing && !redirect);
        end
    end

    always_ff @(posedge clock) begin
        cap_addr <= address;
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clock    (clock),
        .reset    (reset),
        .flush    (redirect),
        .wr_en    (enq),
        .wr_two   (!cap_half),
        .wr_data0 (cap_half ? data[63:32] : data[31:0]),
        .wr_pc0   (cap_half ? cap_addr + 32'd4 : cap_addr),
        .wr_data1 (data[63:32]),
        .wr_pc1   (cap_addr + 32'd4),
        .rd_en    (deq),
        .rd_data  (head_data),
        .rd_pc    (head_pc),
        .count    (count)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue against a queue-level fetch model, plus directed corner cases.
module tb_instr_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h00000000;
    localparam int          DEPTH    = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address;
    logic        mem_read;
    logic [1:0]  size;
    logic [63:0] data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    always #5 clock = ~clock;

    instr_fetch_queue #(
        .RESET_PC    (RESET_PC),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .mem_read    (mem_read),
        .size        (size),
        .data        (data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00000000;
        if (a == 32'h4) return 32'h11111111;
        return (a * 32'h9E3779B1) ^ 32'hC3C3C3C3;
    endfunction

    function automatic logic [63:0] rom_line(input logic [31:0] a);
        return {rom_word(a + 32'd4), rom_word(a)};
    endfunction

    // Reference model: instruction queue plus outstanding line reads, each due at a known edge.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    typedef struct {
        logic [31:0] addr;
        bit          half;
        int          due;
    } read_t;

    entry_t      mq[$];
    read_t       mpend[$];
    logic [31:0] m_fetch;
    logic [31:0] m_addr;
    bit          m_rd;
    int          edge_no;
    bit          prev_rd;
    logic [31:0] prev_addr;

    task automatic model_reset();
        mq.delete();
        mpend.delete();
        m_fetch = RESET_PC;
        m_addr  = RESET_PC;
        m_rd    = 1'b0;
        edge_no = 0;
        prev_rd = 1'b0;
    endtask

    task automatic model_edge(input bit rd, input logic [31:0] rpc, input bit rdy);
        int    busy;
        read_t r;
        busy = mq.size() + 2 * mpend.size();
        edge_no++;
        if (rd) begin
            mq.delete();
            mpend.delete();
            m_addr = {rpc[31:3], 3'b000};
            mpend.push_back('{m_addr, rpc[2], edge_no + 2});
            m_fetch = m_addr + 32'd8;
            m_rd = 1'b1;
        end else begin
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (mpend.size() > 0 && mpend[0].due == edge_no) begin
                r = mpend.pop_front();
                if (!r.half) mq.push_back('{rom_word(r.addr), r.addr});
                mq.push_back('{rom_word(r.addr + 32'd4), r.addr + 32'd4});
            end
            m_rd = (DEPTH - busy) >= 2;
            if (m_rd) begin
                m_addr = m_fetch;
                mpend.push_back('{m_fetch, 1'b0, edge_no + 2});
                m_fetch = m_fetch + 32'd8;
            end
        end
    endtask

    // Called at a falling edge: drives this cycle's inputs, advances one clock, checks the new cycle.
    task automatic step(input bit rd, input logic [31:0] rpc, input bit rdy);
        data = prev_rd ? rom_line(prev_addr) : {$urandom, $urandom};
        prev_rd = mem_read;
        prev_addr = address;
        redirect = rd;
        redirect_pc = rpc;
        instr_ready = rdy;
        @(posedge clock);
        model_edge(rd, rpc, rdy);
        @(negedge clock);
        check("mem_read", mem_read, m_rd);
        check("address", address, m_addr);
        check("size", size, 2'b11);
        check("instr_valid", instr_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            check("instr", instr, mq[0].instr);
            check("instr_pc", instr_pc, mq[0].pc);
        end
    endtask

    task automatic apply_reset(input int hold);
        reset = 1'b0;
        redirect = 1'b0;
        #1;
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_address", address, RESET_PC);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        model_reset();
        repeat (hold) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want summary");
        $fatal(1);
    end

    initial begin
        int          reads;
        logic [31:0] pcs[$];
        logic [31:0] adrs[$];
        logic [31:0] exp_pc [3];
        bit          stall;
        exp_pc = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000};

        @(negedge clock);
        apply_reset(2);

        // Reset release with the consumer always ready.
        step(0, 32'h0, 1);
        check("r34_rd", mem_read, 1'b1);
        check("r34_addr", address, 32'h0);
        step(0, 32'h0, 1);
        step(0, 32'h0, 1);
        check("r34_valid", instr_valid, 1'b1);
        check("r34_i0", instr, 32'h00000000);
        check("r34_pc0", instr_pc, 32'h0);
        step(0, 32'h0, 1);
        check("r34_i1", instr, 32'h11111111);
        check("r34_pc1", instr_pc, 32'h4);

        // Stalled consumer: exactly two lines fetched, then the bus goes quiet.
        @(negedge clock);
        apply_reset(1);
        reads = 0;
        repeat (20) begin
            step(0, 32'h0, 0);
            reads += int'(mem_read);
        end
        check("r35_reads", reads, 2);
        check("r35_rd", mem_read, 1'b0);
        check("r35_count", 32'(dut.u_queue.count), 4);
        check("r35_head", instr, 32'h0);
        check("r35_head_pc", instr_pc, 32'h0);

        // Redirect while lines are in flight.
        apply_reset(1);
        step(0, 32'h0, 0);
        step(0, 32'h0, 0);
        step(1, 32'h00000044, 0);
        check("r36_rd", mem_read, 1'b1);
        check("r36_addr", address, 32'h00000040);
        check("r36_empty0", instr_valid, 1'b0);
        step(0, 32'h0, 0);
        check("r36_empty1", instr_valid, 1'b0);
        step(0, 32'h0, 0);
        check("r36_valid", instr_valid, 1'b1);
        check("r36_pc", instr_pc, 32'h00000044);
        check("r36_instr", instr, rom_word(32'h00000044));

        // Redirect coinciding with a dequeue.
        step(1, 32'h00000100, 1);
        check("r37_empty", instr_valid, 1'b0);
        step(0, 32'h0, 1);
        step(0, 32'h0, 1);
        check("r37_pc", instr_pc, 32'h00000100);

        // Address wrap at the top of memory.
        step(1, 32'hFFFFFFF8, 1);
        check("r38_addr0", address, 32'hFFFFFFF8);
        adrs.push_back(address);
        for (int i = 0; i < 20 && pcs.size() < 3; i++) begin
            if (instr_valid) pcs.push_back(instr_pc);
            step(0, 32'h0, 1);
            if (mem_read) adrs.push_back(address);
        end
        check("r38_npcs", pcs.size(), 3);
        for (int i = 0; i < pcs.size() && i < 3; i++) check("r38_pc", pcs[i], exp_pc[i]);
        check("r38_naddr", adrs.size() >= 2, 1'b1);
        if (adrs.size() >= 2) check("r38_addr1", adrs[1], 32'h00000000);

        // Reset one cycle after a read strobe.
        apply_reset(1);
        step(0, 32'h0, 0);
        step(0, 32'h0, 0);
        data = rom_line(32'h0);
        apply_reset(1);
        step(0, 32'h0, 0);
        check("r39_rd", mem_read, 1'b1);
        check("r39_addr", address, RESET_PC);
        step(0, 32'h0, 0);
        check("r39_empty", instr_valid, 1'b0);
        step(0, 32'h0, 0);
        check("r39_pc", instr_pc, RESET_PC);

        // Random traffic with stall phases, redirects and occasional resets.
        stall = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rpc;
            if (i % 100 == 0) stall = ($urandom_range(0, 1) == 1);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFE0 | ($urandom & 32'h1F)) : $urandom;
            if ($urandom_range(0, 199) == 0) begin
                apply_reset($urandom_range(1, 2));
            end else begin
                step($urandom_range(0, 15) == 0, rpc,
                     stall ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
